// File: rtl/mdu_pkg.sv
// ============================================================================
// Module   : mdu_pkg
// Purpose  : Shared constants, state enum and op-class struct for the MIPS
//            multiply/divide unit. SPECIAL2 codes are used only when
//            MDU_MADD_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mdu_pkg;

    localparam logic [5:0] c_OP_SPECIAL  = 6'b000000;
    localparam logic [5:0] c_OP_SPECIAL2 = 6'b011100;

    localparam logic [5:0] c_FN_MULT  = 6'b011000;
    localparam logic [5:0] c_FN_MULTU = 6'b011001;
    localparam logic [5:0] c_FN_DIV   = 6'b011010;
    localparam logic [5:0] c_FN_DIVU  = 6'b011011;
    localparam logic [5:0] c_FN_MTHI  = 6'b010001;
    localparam logic [5:0] c_FN_MTLO  = 6'b010011;
    localparam logic [5:0] c_FN_MFHI  = 6'b010000;
    localparam logic [5:0] c_FN_MFLO  = 6'b010010;

    localparam logic [5:0] c_FN_MADD  = 6'b000000;
    localparam logic [5:0] c_FN_MADDU = 6'b000001;
    localparam logic [5:0] c_FN_MSUB  = 6'b000100;
    localparam logic [5:0] c_FN_MSUBU = 6'b000101;

    localparam int c_MULT_CYCLES_DEF = 5;
    localparam int c_DIV_CYCLES_DEF  = 10;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } mdu_state_t;

    // One-hot class of the accepted multi-cycle operation
    typedef struct packed {
        logic mult;
        logic multu;
        logic div;
        logic divu;
        logic madd;
        logic maddu;
        logic msub;
        logic msubu;
    } md_cls_t;

endpackage

`default_nettype wire

// File: rtl/mdu_if.sv
// ============================================================================
// Module   : mdu_if
// Purpose  : E-stage pipeline <-> multiply/divide unit signal bundle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mdu_if;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        start;
    logic        busy;
    logic        md_use;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] md_out;

    modport master (
        output instr, instr_valid, rs_val, rt_val,
        input  start, busy, md_use, hi, lo, md_out
    );

    modport slave (
        input  instr, instr_valid, rs_val, rt_val,
        output start, busy, md_use, hi, lo, md_out
    );
endinterface

`default_nettype wire

// File: rtl/mdu_decode.sv
// ============================================================================
// Module   : mdu_decode
// Purpose  : Combinational HI/LO instruction decoder. SPECIAL2 madd/msub
//            family decoded only when MDU_MADD_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mdu_decode
    import mdu_pkg::*;
(
    input  wire logic [31:0] instr,
    input  wire logic        instr_valid,
    output md_cls_t          cls,
    output logic             is_mthi,
    output logic             is_mtlo,
    output logic             is_mfhi,
    output logic             is_mflo,
    output logic             md_use
);

    logic [5:0] w_op;
    logic [5:0] w_func;
    logic       w_unused_fields;

    assign w_op            = instr[31:26];
    assign w_func          = instr[5:0];
    assign w_unused_fields = ^instr[25:6];

    always_comb begin
        cls     = '0;
        is_mthi = 1'b0;
        is_mtlo = 1'b0;
        is_mfhi = 1'b0;
        is_mflo = 1'b0;
        if (instr_valid) begin
            if (w_op == c_OP_SPECIAL) begin
                case (w_func)
                    c_FN_MULT:  cls.mult  = 1'b1;
                    c_FN_MULTU: cls.multu = 1'b1;
                    c_FN_DIV:   cls.div   = 1'b1;
                    c_FN_DIVU:  cls.divu  = 1'b1;
                    c_FN_MTHI:  is_mthi   = 1'b1;
                    c_FN_MTLO:  is_mtlo   = 1'b1;
                    c_FN_MFHI:  is_mfhi   = 1'b1;
                    c_FN_MFLO:  is_mflo   = 1'b1;
                    default: ;
                endcase
            end
`ifdef MDU_MADD_EN
            if (w_op == c_OP_SPECIAL2) begin
                case (w_func)
                    c_FN_MADD:  cls.madd  = 1'b1;
                    c_FN_MADDU: cls.maddu = 1'b1;
                    c_FN_MSUB:  cls.msub  = 1'b1;
                    c_FN_MSUBU: cls.msubu = 1'b1;
                    default: ;
                endcase
            end
`endif
        end
    end

    assign md_use = (|cls) | is_mthi | is_mtlo | is_mfhi | is_mflo;

endmodule

`default_nettype wire

// File: rtl/mult_div_unit.sv
// ============================================================================
// Module   : mult_div_unit
// Purpose  : E-stage multiply/divide unit owning HI/LO, with a fixed-latency
//            busy window. MDU_MADD_EN adds madd/maddu/msub/msubu.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = c_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = c_DIV_CYCLES_DEF
) (
    input wire logic clk,
    input wire logic reset,
    mdu_if.slave     bus
);

    localparam int c_MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int c_CNT_W      = $clog2(c_MAX_CYCLES + 1);

    md_cls_t            w_cls;
    logic               w_mthi, w_mtlo, w_mfhi, w_mflo, w_md_use;
    mdu_state_t         r_state, w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [63:0]        r_pend, w_res, w_acc;
    logic               r_pend_we, w_res_we;
    logic [31:0]        r_hi, r_lo;
    logic               w_start, w_busy, w_done, w_is_div;
    logic [31:0]        w_a, w_b, w_a_mag, w_b_mag, w_q_mag, w_r_mag, w_sq, w_sr;
    logic [63:0]        w_sprod, w_uprod;

    mdu_decode u_decode (
        .instr       (bus.instr),
        .instr_valid (bus.instr_valid),
        .cls         (w_cls),
        .is_mthi     (w_mthi),
        .is_mtlo     (w_mtlo),
        .is_mfhi     (w_mfhi),
        .is_mflo     (w_mflo),
        .md_use      (w_md_use)
    );

    assign w_busy   = (r_state == S_BUSY);
    assign w_start  = bus.instr_valid & ~w_busy & (|w_cls);
    assign w_is_div = w_cls.div | w_cls.divu;

    assign w_a   = bus.rs_val;
    assign w_b   = bus.rt_val;
    assign w_acc = {r_hi, r_lo};

    // Low 64 bits of a 64x64 product are sign-correct for sign-extended inputs
    assign w_sprod = {{32{w_a[31]}}, w_a} * {{32{w_b[31]}}, w_b};
    assign w_uprod = {32'd0, w_a} * {32'd0, w_b};

    // Signed divide through magnitudes; 0x80000000 / -1 falls out as 0x80000000 r 0
    assign w_a_mag = w_a[31] ? (32'd0 - w_a) : w_a;
    assign w_b_mag = w_b[31] ? (32'd0 - w_b) : w_b;
    assign w_q_mag = w_a_mag / w_b_mag;
    assign w_r_mag = w_a_mag % w_b_mag;
    assign w_sq    = (w_a[31] ^ w_b[31]) ? (32'd0 - w_q_mag) : w_q_mag;
    assign w_sr    = w_a[31] ? (32'd0 - w_r_mag) : w_r_mag;

    always_comb begin
        w_res    = '0;
        w_res_we = 1'b1;
        if (w_cls.mult) begin
            w_res = w_sprod;
        end else if (w_cls.multu) begin
            w_res = w_uprod;
        end else if (w_cls.div) begin
            w_res    = {w_sr, w_sq};
            w_res_we = |w_b;
        end else if (w_cls.divu) begin
            w_res    = {w_a % w_b, w_a / w_b};
            w_res_we = |w_b;
        end else if (w_cls.madd) begin
            w_res = w_acc + w_sprod;
        end else if (w_cls.maddu) begin
            w_res = w_acc + w_uprod;
        end else if (w_cls.msub) begin
            w_res = w_acc - w_sprod;
        end else if (w_cls.msubu) begin
            w_res = w_acc - w_uprod;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                if (r_cnt == c_CNT_W'(1)) begin
                    w_state_nxt = S_IDLE;
                    w_done      = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt     <= '0;
            r_pend    <= '0;
            r_pend_we <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            if (w_start) begin
                r_cnt     <= w_is_div ? c_CNT_W'(DIV_CYCLES) : c_CNT_W'(MULT_CYCLES);
                r_pend    <= w_res;
                r_pend_we <= w_res_we;
            end else if (w_busy) begin
                r_cnt <= r_cnt - c_CNT_W'(1);
            end

            // Divide-by-zero completes the busy window but leaves HI/LO alone
            if (w_done) begin
                if (r_pend_we) begin
                    {r_hi, r_lo} <= r_pend;
                end
            end else if (!w_busy) begin
                if (w_mthi) r_hi <= bus.rs_val;
                if (w_mtlo) r_lo <= bus.rs_val;
            end
        end
    end

    assign bus.start  = w_start;
    assign bus.busy   = w_busy;
    assign bus.md_use = w_md_use;
    assign bus.hi     = r_hi;
    assign bus.lo     = r_lo;
    assign bus.md_out = w_mfhi ? r_hi : (w_mflo ? r_lo : 32'd0);

endmodule

`default_nettype wire

// File: tb/tb_mult_div_unit.sv
// ============================================================================
// Module   : tb_mult_div_unit
// Purpose  : Self-checking bench for mult_div_unit against an arithmetic
//            reference model. Honours MDU_MADD_EN for the SPECIAL2 checks.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mult_div_unit;

    localparam logic [5:0] OP_SP   = 6'b000000;
    localparam logic [5:0] OP_SP2  = 6'b011100;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MADD  = 6'b000000;
    localparam logic [5:0] F_MADDU = 6'b000001;
    localparam logic [5:0] F_MSUB  = 6'b000100;
    localparam logic [5:0] F_MSUBU = 6'b000101;
    localparam int         NMUL    = 5;
    localparam int         NDIV    = 10;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mdu_if bus ();

    mult_div_unit #(.MULT_CYCLES(NMUL), .DIV_CYCLES(NDIV)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int          n_pass  = 0;
    int          n_total = 0;
    logic [31:0] ref_hi  = '0;
    logic [31:0] ref_lo  = '0;

    // Returns {write_enable, hi, lo} for an accepted op given the accumulator {hi,lo}
    function automatic logic [64:0] model(input logic [5:0] op, input logic [5:0] func,
                                          input logic [31:0] a, input logic [31:0] b,
                                          input logic [63:0] acc);
        longint      sa, sb, q, r;
        logic [63:0] sp, up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sp = sa * sb;
        up = {32'd0, a} * {32'd0, b};
        model = {1'b0, acc};
        if (op == OP_SP) begin
            case (func)
                F_MULT:  model = {1'b1, sp};
                F_MULTU: model = {1'b1, up};
                F_DIV:   if (b != 0) begin
                             q = sa / sb;
                             r = sa % sb;
                             model = {1'b1, r[31:0], q[31:0]};
                         end
                F_DIVU:  if (b != 0) model = {1'b1, a % b, a / b};
                default: ;
            endcase
        end
`ifdef MDU_MADD_EN
        else if (op == OP_SP2) begin
            case (func)
                F_MADD:  model = {1'b1, acc + sp};
                F_MADDU: model = {1'b1, acc + up};
                F_MSUB:  model = {1'b1, acc - sp};
                F_MSUBU: model = {1'b1, acc - up};
                default: ;
            endcase
        end
`endif
    endfunction

    task automatic drive(input logic [5:0] op, input logic [5:0] func,
                         input logic [31:0] a, input logic [31:0] b);
        logic [31:0] rnd;
        rnd = $urandom;
        bus.instr       = {op, rnd[19:0], func};
        bus.instr_valid = 1'b1;
        bus.rs_val      = a;
        bus.rt_val      = b;
    endtask

    task automatic idle_inputs();
        bus.instr_valid = 1'b0;
        bus.instr       = $urandom;
        bus.rs_val      = $urandom;
        bus.rt_val      = $urandom;
    endtask

    // Entered and left 1 time unit after a rising edge
    task automatic issue_and_wait(input logic [5:0] op, input logic [5:0] func,
                                  input logic [31:0] a, input logic [31:0] b,
                                  output logic st, output logic mu, output int cyc);
        drive(op, func, a, b);
        #1;
        st = bus.start;
        mu = bus.md_use;
        @(posedge clk); #1;
        idle_inputs();
        cyc = 0;
        while (bus.busy === 1'b1 && cyc < 60) begin
            cyc++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        #2;
        n_total++;
        if (bus.busy !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
            $display("FAIL reset_state: busy=%b hi=%h lo=%h required 0/0/0", bus.busy, bus.hi, bus.lo);
        end else n_pass++;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        #1;
        n_total++;
        if (bus.start !== 1'b0 || bus.md_use !== 1'b0 || bus.md_out !== 32'd0) begin
            $display("FAIL reset_idle_out: start=%b md_use=%b md_out=%h required 0/0/0",
                     bus.start, bus.md_use, bus.md_out);
        end else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_mult();
        logic [64:0] exp;
        logic st, mu;
        int cyc;
        exp = model(OP_SP, F_MULT, 32'hFFFFFFFE, 32'd3, {ref_hi, ref_lo});
        issue_and_wait(OP_SP, F_MULT, 32'hFFFFFFFE, 32'd3, st, mu, cyc);
        n_total++;
        if (st !== 1'b1 || cyc != NMUL || bus.hi !== 32'hFFFFFFFF || bus.lo !== 32'hFFFFFFFA
            || bus.hi !== exp[63:32]) begin
            $display("FAIL mult_vec: start=%b cyc=%0d hi=%h lo=%h required 1 %0d FFFFFFFF FFFFFFFA",
                     st, cyc, bus.hi, bus.lo, NMUL);
        end else n_pass++;
        {ref_hi, ref_lo} = exp[63:0];
        issue_and_wait(OP_SP, F_MULTU, 32'hFFFFFFFE, 32'd3, st, mu, cyc);
        n_total++;
        if (st !== 1'b1 || cyc != NMUL || bus.hi !== 32'h00000002 || bus.lo !== 32'hFFFFFFFA) begin
            $display("FAIL multu_vec: start=%b cyc=%0d hi=%h lo=%h required 1 %0d 00000002 FFFFFFFA",
                     st, cyc, bus.hi, bus.lo, NMUL);
        end else n_pass++;
        {ref_hi, ref_lo} = {32'h2, 32'hFFFFFFFA};
    endtask

    task automatic test_div();
        logic st, mu;
        int cyc;
        issue_and_wait(OP_SP, F_DIV, 32'hFFFFFFF9, 32'd2, st, mu, cyc);
        n_total++;
        if (st !== 1'b1 || cyc != NDIV || bus.hi !== 32'hFFFFFFFF || bus.lo !== 32'hFFFFFFFD) begin
            $display("FAIL div_vec: start=%b cyc=%0d hi=%h lo=%h required 1 %0d FFFFFFFF FFFFFFFD",
                     st, cyc, bus.hi, bus.lo, NDIV);
        end else n_pass++;
        {ref_hi, ref_lo} = {32'hFFFFFFFF, 32'hFFFFFFFD};
        issue_and_wait(OP_SP, F_DIVU, 32'd7, 32'd0, st, mu, cyc);
        n_total++;
        if (st !== 1'b1 || cyc != NDIV || bus.hi !== ref_hi || bus.lo !== ref_lo) begin
            $display("FAIL divu_by_zero: start=%b cyc=%0d hi=%h lo=%h required 1 %0d %h %h",
                     st, cyc, bus.hi, bus.lo, NDIV, ref_hi, ref_lo);
        end else n_pass++;
        issue_and_wait(OP_SP, F_DIV, 32'h80000000, 32'hFFFFFFFF, st, mu, cyc);
        n_total++;
        if (cyc != NDIV || bus.hi !== 32'd0 || bus.lo !== 32'h80000000) begin
            $display("FAIL div_overflow: cyc=%0d hi=%h lo=%h required %0d 00000000 80000000",
                     cyc, bus.hi, bus.lo, NDIV);
        end else n_pass++;
        {ref_hi, ref_lo} = {32'd0, 32'h80000000};
    endtask

    task automatic test_overlap();
        logic [64:0] exp;
        int cyc;
        exp = model(OP_SP, F_MULT, 32'd1000, 32'hFFFFFF00, {ref_hi, ref_lo});
        drive(OP_SP, F_MULT, 32'd1000, 32'hFFFFFF00);
        @(posedge clk); #1;
        idle_inputs();
        @(posedge clk); #1;
        drive(OP_SP, F_MULT, 32'd77, 32'd99);
        #1;
        n_total++;
        if (bus.start !== 1'b0 || bus.busy !== 1'b1) begin
            $display("FAIL overlap_mult: start=%b busy=%b required 0 1", bus.start, bus.busy);
        end else n_pass++;
        @(posedge clk); #1;
        drive(OP_SP, F_MTHI, 32'h1234, 32'd0);
        #1;
        n_total++;
        if (bus.start !== 1'b0 || bus.md_use !== 1'b1) begin
            $display("FAIL overlap_mthi: start=%b md_use=%b required 0 1", bus.start, bus.md_use);
        end else n_pass++;
        @(posedge clk); #1;
        idle_inputs();
        cyc = 0;
        while (bus.busy === 1'b1 && cyc < 60) begin
            cyc++;
            @(posedge clk); #1;
        end
        n_total++;
        if (cyc != NMUL - 3 || bus.hi !== exp[63:32] || bus.lo !== exp[31:0]) begin
            $display("FAIL overlap_result: remaining=%0d hi=%h lo=%h required %0d %h %h",
                     cyc, bus.hi, bus.lo, NMUL - 3, exp[63:32], exp[31:0]);
        end else n_pass++;
        {ref_hi, ref_lo} = exp[63:0];
    endtask

    task automatic test_mt_mf();
        drive(OP_SP, F_MTLO, 32'hCAFEBABE, 32'd0);
        #1;
        n_total++;
        if (bus.md_use !== 1'b1 || bus.start !== 1'b0) begin
            $display("FAIL mtlo_decode: md_use=%b start=%b required 1 0", bus.md_use, bus.start);
        end else n_pass++;
        @(posedge clk); #1;
        ref_lo = 32'hCAFEBABE;
        n_total++;
        if (bus.busy !== 1'b0 || bus.lo !== ref_lo || bus.hi !== ref_hi) begin
            $display("FAIL mtlo_write: busy=%b hi=%h lo=%h required 0 %h %h", bus.busy, bus.hi, bus.lo, ref_hi, ref_lo);
        end else n_pass++;
        drive(OP_SP, F_MFLO, 32'd0, 32'd0);
        #1;
        n_total++;
        if (bus.md_use !== 1'b1 || bus.md_out !== 32'hCAFEBABE) begin
            $display("FAIL mflo_read: md_use=%b md_out=%h required 1 CAFEBABE", bus.md_use, bus.md_out);
        end else n_pass++;
        @(posedge clk); #1;
        drive(OP_SP, F_MFHI, 32'd0, 32'd0);
        #1;
        n_total++;
        if (bus.md_out !== ref_hi) begin
            $display("FAIL mfhi_read: md_out=%h required %h", bus.md_out, ref_hi);
        end else n_pass++;
        bus.instr_valid = 1'b0;
        bus.instr       = {OP_SP, 20'd0, F_MFLO};
        #1;
        n_total++;
        if (bus.md_use !== 1'b0 || bus.md_out !== 32'd0 || bus.start !== 1'b0) begin
            $display("FAIL invalid_bubble: md_use=%b md_out=%h start=%b required 0 0 0",
                     bus.md_use, bus.md_out, bus.start);
        end else n_pass++;
        @(posedge clk); #1;
        idle_inputs();
    endtask

    task automatic test_random();
        logic [5:0]  funcs [4] = '{F_MULT, F_MULTU, F_DIV, F_DIVU};
        logic [5:0]  f;
        logic [31:0] a, b;
        logic [64:0] exp;
        logic st, mu;
        int cyc;
        for (int i = 0; i < 16; i++) begin
            f = funcs[$urandom_range(0, 3)];
            a = $urandom;
            b = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) b = b & 32'h0000001F;
            exp = model(OP_SP, f, a, b, {ref_hi, ref_lo});
            issue_and_wait(OP_SP, f, a, b, st, mu, cyc);
            if (exp[64]) {ref_hi, ref_lo} = exp[63:0];
            n_total++;
            if (st !== 1'b1 || mu !== 1'b1
                || cyc != (((f == F_DIV) || (f == F_DIVU)) ? NDIV : NMUL)
                || bus.hi !== ref_hi || bus.lo !== ref_lo) begin
                $display("FAIL random_op%0d f=%b a=%h b=%h: start=%b cyc=%0d hi=%h lo=%h required hi=%h lo=%h",
                         i, f, a, b, st, cyc, bus.hi, bus.lo, ref_hi, ref_lo);
            end else n_pass++;
        end
    endtask

    task automatic test_madd();
        logic st, mu;
        int cyc;
        logic [64:0] exp;
        logic [5:0]  f;
        logic [31:0] a, b;
        issue_and_wait(OP_SP, F_MTHI, 32'd0, 32'd0, st, mu, cyc);
        issue_and_wait(OP_SP, F_MTLO, 32'd10, 32'd0, st, mu, cyc);
        ref_hi = 32'd0;
        ref_lo = 32'd10;
        issue_and_wait(OP_SP2, F_MADD, 32'd4, 32'd5, st, mu, cyc);
`ifdef MDU_MADD_EN
        n_total++;
        if (st !== 1'b1 || mu !== 1'b1 || cyc != NMUL || bus.hi !== 32'd0 || bus.lo !== 32'd30) begin
            $display("FAIL madd_vec: start=%b md_use=%b cyc=%0d hi=%h lo=%h required 1 1 %0d 0 1e",
                     st, mu, cyc, bus.hi, bus.lo, NMUL);
        end else n_pass++;
        ref_lo = 32'd30;
        for (int i = 0; i < 6; i++) begin
            case ($urandom_range(0, 3))
                0: f = F_MADD;
                1: f = F_MADDU;
                2: f = F_MSUB;
                default: f = F_MSUBU;
            endcase
            a = $urandom;
            b = $urandom;
            exp = model(OP_SP2, f, a, b, {ref_hi, ref_lo});
            issue_and_wait(OP_SP2, f, a, b, st, mu, cyc);
            {ref_hi, ref_lo} = exp[63:0];
            n_total++;
            if (st !== 1'b1 || cyc != NMUL || bus.hi !== ref_hi || bus.lo !== ref_lo) begin
                $display("FAIL madd_rand%0d f=%b: start=%b cyc=%0d hi=%h lo=%h required hi=%h lo=%h",
                         i, f, st, cyc, bus.hi, bus.lo, ref_hi, ref_lo);
            end else n_pass++;
        end
`else
        f = F_MADD;
        a = 32'd0;
        b = 32'd0;
        exp = '0;
        n_total++;
        if (st !== 1'b0 || mu !== 1'b0 || cyc != 0 || bus.hi !== 32'd0 || bus.lo !== 32'd10) begin
            $display("FAIL madd_disabled: start=%b md_use=%b cyc=%0d hi=%h lo=%h required 0 0 0 0 a",
                     st, mu, cyc, bus.hi, bus.lo);
        end else n_pass++;
        repeat (NMUL + 1) @(posedge clk);
        #1;
        n_total++;
        if (bus.hi !== 32'd0 || bus.lo !== 32'd10 || bus.busy !== 1'b0) begin
            $display("FAIL madd_disabled_late: hi=%h lo=%h busy=%b required 0 a 0", bus.hi, bus.lo, bus.busy);
        end else n_pass++;
`endif
    endtask

    task automatic test_reset_mid();
        logic st, mu;
        int cyc;
        int seen_busy;
        issue_and_wait(OP_SP, F_MTHI, 32'h55AA55AA, 32'd0, st, mu, cyc);
        issue_and_wait(OP_SP, F_MTLO, 32'h0F0F0F0F, 32'd0, st, mu, cyc);
        drive(OP_SP, F_DIV, 32'd100, 32'd7);
        @(posedge clk); #1;
        idle_inputs();
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;
        #1;
        n_total++;
        if (bus.busy !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
            $display("FAIL reset_mid_async: busy=%b hi=%h lo=%h required 0 0 0", bus.busy, bus.hi, bus.lo);
        end else n_pass++;
        @(posedge clk); #1;
        reset = 1'b0;
        ref_hi = 32'd0;
        ref_lo = 32'd0;
        seen_busy = 0;
        for (int i = 0; i < NDIV + 5; i++) begin
            @(posedge clk); #1;
            if (bus.busy !== 1'b0) seen_busy++;
        end
        n_total++;
        if (seen_busy != 0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
            $display("FAIL reset_mid_no_writeback: busy_cycles=%0d hi=%h lo=%h required 0 0 0",
                     seen_busy, bus.hi, bus.lo);
        end else n_pass++;
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_overlap();
        test_mt_mf();
        test_random();
        test_madd();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- E-stage multiply/divide unit of the 5-stage MIPS pipeline; owns the HI/LO registers.
- Writer side of the HI/LO interface: accepts mult/multu/div/divu/mthi/mtlo and models a multi-cycle busy period.
- Serves mfhi/mflo reads to the pipeline, which carries the value to W as an ordinary register write.
- Exports busy/start so the hazard unit stalls any HI/LO instruction in D while an operation is outstanding.

Parameters:
- MULT_CYCLES, 5, cycles busy is high after accepting mult/multu (>=1)
- DIV_CYCLES, 10, cycles busy is high after accepting div/divu (>=1)

Ports:
- clk  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-high; clears all state
- instr  input  32  E-stage instruction; op = bits 31:26, func = bits 5:0
- instr_valid  input  1  1 = instr is real (0 for bubble/flush)
- rs_val  input  32  forwarded rs operand
- rt_val  input  32  forwarded rt operand
- start  output  1  combinational; a mult/div class op is accepted this cycle
- busy  output  1  registered; operation in flight
- md_use  output  1  combinational; instr is any HI/LO instruction (read or write), for the hazard unit
- hi  output  32  HI register
- lo  output  32  LO register
- md_out  output  32  mfhi ? hi : mflo ? lo : 0

Behaviour:
- Decode (op = 000000):
  - mult func 011000, multu 011001, div 011010, divu 011011.
  - mthi 010001, mtlo 010011, mfhi 010000, mflo 010010.
- Reset values: hi = 0, lo = 0, busy = 0, state = IDLE, counter = 0, pending result = 0.
- States:
  - IDLE -> BUSY on accept of mult/multu/div/divu.
  - BUSY -> IDLE when counter reaches 1.
- Accept rule: start = instr_valid & !busy & (mult|multu|div|divu).
- Latency:
  - Operation accepted at edge T (start = 1 in the cycle before T).
  - busy = 1 from T for N cycles; counter loads N at T and decrements each edge.
  - At edge T+N: hi/lo take the pending result and busy drops. N = MULT_CYCLES or DIV_CYCLES.
- Arithmetic, computed from rs_val/rt_val at accept and held in a pending register (so later operand changes are irrelevant):
  - mult: signed 64-bit product; hi = upper 32 bits, lo = lower 32 bits.
  - multu: same, unsigned.
  - div: lo = signed quotient truncated toward zero, hi = remainder with the sign of the dividend.
  - divu: same, unsigned.
  - Divide by zero: busy sequence runs normally; hi/lo keep their prior values at completion.
  - 0x80000000 / -1 (div): lo = 0x80000000, hi = 0.
- mthi/mtlo:
  - When instr_valid & !busy: hi (or lo) = rs_val at the next edge; busy is unaffected.
  - When busy: ignored. The hazard unit must stall (busy | start) & md_use in D, so this case never occurs legally.
- Ignored while busy: any mult/div/mt* presented; no state change, no error.
- mfhi/mflo:
  - md_out reflects the current register values combinationally.
  - During busy it returns the pre-operation values; correctness relies on the external stall.
- instr_valid = 0: the block decodes nothing; start = 0, md_use = 0.
- Reset mid-operation: asynchronous return to IDLE, pending result discarded, hi = lo = 0 immediately.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined: adds the SPECIAL2 ops (op 011100): madd func 000000, maddu 000001, msub 000100, msubu 000101.
  - Result = {hi,lo} ± rs*rt (signed/unsigned), using {hi,lo} as sampled at accept.
  - Latency MULT_CYCLES; these ops count toward start and md_use.
- Undefined: these encodings are not decoded (start = 0, md_use = 0) and have no effect.

Decomposition:
- Package mdu_pkg:
  - op/func constants for all HI/LO instructions (and SPECIAL2 ones).
  - State enum (IDLE, BUSY) and default latency constants.
- Sub-module mdu_decode: combinational instr/instr_valid -> one-hot op class, is_mt, is_mf, md_use.
- Top: counter, FSM, pending register, HI/LO registers, md_out mux.

Test Plan:
- mult: rs = 0xFFFFFFFE, rt = 3 -> busy = 1 for exactly 5 cycles; then hi = 0xFFFFFFFF, lo = 0xFFFFFFFA. Same operands with multu -> hi = 0x00000002, lo = 0xFFFFFFFA.
- div: rs = -7, rt = 2 -> after 10 busy cycles lo = 0xFFFFFFFD (-3), hi = 0xFFFFFFFF (-1). divu: 7 / 0 -> hi/lo unchanged, busy still high for 10 cycles.
- Overlap: a second mult is presented 2 cycles after a first one is accepted -> start = 0, ignored; result equals the first op only. mthi 0x1234 while busy -> ignored.
- mtlo rs = 0xCAFEBABE while idle -> lo updated at the next edge, busy stays 0; mflo -> md_out = 0xCAFEBABE; md_use = 1 in both cycles.
- Assert reset 3 cycles into a div -> busy = 0, hi = lo = 0 immediately; no late writeback after reset is released.
- With MDU_MADD_EN: hi:lo = 0:10, madd rs = 4, rt = 5 -> lo = 30 after 5 cycles. Without the macro: the same encoding gives start = 0 and hi/lo unchanged.
